// File: rtl/loop_nest_ctrl_if.sv
// Handshake and configuration bundle between a loop requester and loop_nest_ctrl.
// The master drives launch/config/backpressure; the slave (controller) returns the index stream.
interface loop_nest_ctrl_if #(
  parameter int IW = 5,
  parameter int OW = 5
);
  logic          start;
  logic          abort;
  logic [IW-1:0] cfg_inner_n;
  logic [OW-1:0] cfg_outer_n;
  logic          step_ready;
  logic          idx_valid;
  logic [IW-1:0] inner_j;
  logic [OW-1:0] outer_t;
  logic          inner_last;
  logic          outer_last;
  logic          busy;
  logic          done;
  logic          cfg_err;

  modport master (
    output start, abort, cfg_inner_n, cfg_outer_n, step_ready,
    input  idx_valid, inner_j, outer_t, inner_last, outer_last, busy, done, cfg_err
  );

  modport slave (
    input  start, abort, cfg_inner_n, cfg_outer_n, step_ready,
    output idx_valid, inner_j, outer_t, inner_last, outer_last, busy, done, cfg_err
  );
endinterface

// File: rtl/loop_nest_ctrl.sv
// Two-level 1-based loop sequencer: walks inner j (1..N) inside outer t (1..T),
// one index pair per accepted valid/ready step, with start/done, abort and config checking.
module loop_nest_ctrl #(
  parameter int IW = 5,
  parameter int OW = 5
) (
  input  logic            clk,
  input  logic            rst,
  loop_nest_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [IW-1:0] r_j;
  logic [OW-1:0] r_t;
  logic [IW-1:0] r_n;
  logic [OW-1:0] r_tn;
  logic          r_cfg_err;

  logic w_accept;
  logic w_j_end;
  logic w_t_end;
  logic w_cfg_bad;

  assign w_accept  = (r_state == S_RUN) && bus.step_ready;
  assign w_j_end   = (r_j == r_n);
  assign w_t_end   = (r_t == r_tn);
  assign w_cfg_bad = (bus.cfg_inner_n == '0) || (bus.cfg_outer_n == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start && !w_cfg_bad) w_next = S_RUN;
      S_RUN:   if (w_accept && w_j_end && w_t_end) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
    if (bus.abort) w_next = S_IDLE;
  end

  // Indices compare by equality with the latched counts, so they stop at N/T and never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_j       <= IW'(1);
      r_t       <= OW'(1);
      r_n       <= '0;
      r_tn      <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= 1'b0;
      if (bus.abort) begin
        r_j <= IW'(1);
        r_t <= OW'(1);
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              if (w_cfg_bad) begin
                r_cfg_err <= 1'b1;
              end else begin
                r_n  <= bus.cfg_inner_n;
                r_tn <= bus.cfg_outer_n;
                r_j  <= IW'(1);
                r_t  <= OW'(1);
              end
            end
          end
          S_RUN: begin
            if (w_accept) begin
              if (!w_j_end) begin
                r_j <= r_j + IW'(1);
              end else if (!w_t_end) begin
                r_j <= IW'(1);
                r_t <= r_t + OW'(1);
              end
            end
          end
          default: begin
            r_j <= IW'(1);
            r_t <= OW'(1);
          end
        endcase
      end
    end
  end

  always_comb begin
    bus.idx_valid  = (r_state == S_RUN);
    bus.busy       = (r_state == S_RUN);
    bus.done       = (r_state == S_DONE);
    bus.inner_j    = r_j;
    bus.outer_t    = r_t;
    bus.inner_last = (r_state == S_RUN) && w_j_end;
    bus.outer_last = (r_state == S_RUN) && w_j_end && w_t_end;
    bus.cfg_err    = r_cfg_err;
  end

endmodule

// File: tb/tb_loop_nest_ctrl.sv
// Bench for loop_nest_ctrl: expected (t,j) order built by nested loops into a queue,
// consumed one entry per accepted step under directed and randomized backpressure.
module tb_loop_nest_ctrl;
  localparam int IW = 5;
  localparam int OW = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  loop_nest_ctrl_if #(.IW(IW), .OW(OW)) bus ();
  loop_nest_ctrl #(.IW(IW), .OW(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int t;
    int j;
  } pair_t;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(bus.idx_valid), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_j"}, 32'(bus.inner_j), 1);
    chk({tag, "_t"}, 32'(bus.outer_t), 1);
  endtask

  // One launch; mode 0 = always ready, 1 = ready alternating 0,1,..., 2 = random.
  task automatic run_seq(input int n, input int tt, input int mode, input int abort_at,
                         input bit noisy, output int vcycles);
    pair_t q[$];
    pair_t p;
    int    budget;
    int    k;
    bit    rdy;
    q.delete();
    for (int ti = 1; ti <= tt; ti++)
      for (int ji = 1; ji <= n; ji++) begin
        p.t = ti;
        p.j = ji;
        q.push_back(p);
      end
    bus.cfg_inner_n = IW'(n);
    bus.cfg_outer_n = OW'(tt);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.cfg_inner_n = IW'($urandom);
    bus.cfg_outer_n = OW'($urandom);
    vcycles = 0;
    k = 0;
    budget = 4 * n * tt + 10;
    while (q.size() > 0 && budget > 0) begin
      budget--;
      p = q[0];
      chk("valid", 32'(bus.idx_valid), 1);
      chk("busy", 32'(bus.busy), 1);
      chk("inner_j", 32'(bus.inner_j), 32'(p.j));
      chk("outer_t", 32'(bus.outer_t), 32'(p.t));
      chk("inner_last", 32'(bus.inner_last), 32'(p.j == n));
      chk("outer_last", 32'(bus.outer_last), 32'((p.j == n) && (p.t == tt)));
      chk("done_early", 32'(bus.done), 0);
      vcycles++;
      if (k == abort_at) begin
        bus.abort = 1'b1;
        bus.step_ready = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.step_ready = 1'b0;
        chk_idle("abort");
        chk("abort_done", 32'(bus.done), 0);
        @(negedge clk);
        chk("abort_done2", 32'(bus.done), 0);
        chk("abort_valid2", 32'(bus.idx_valid), 0);
        return;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (vcycles % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.step_ready = rdy;
      if (noisy) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.cfg_inner_n = IW'($urandom);
        bus.cfg_outer_n = OW'($urandom);
      end
      @(negedge clk);
      if (rdy) begin
        void'(q.pop_front());
        k++;
      end
    end
    bus.step_ready = 1'b0;
    bus.start = 1'b0;
    chk("run_budget", 32'(q.size()), 0);
    chk("done", 32'(bus.done), 1);
    chk("done_valid", 32'(bus.idx_valid), 0);
    chk("done_busy", 32'(bus.busy), 0);
    chk("hold_j", 32'(bus.inner_j), 32'(n));
    chk("hold_t", 32'(bus.outer_t), 32'(tt));
    @(negedge clk);
    chk("done_clr", 32'(bus.done), 0);
    chk_idle("after_done");
  endtask

  task automatic bad_cfg(input int n, input int tt);
    bus.cfg_inner_n = IW'(n);
    bus.cfg_outer_n = OW'(tt);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("cfg_err", 32'(bus.cfg_err), 1);
    chk_idle("cfg_err");
    @(negedge clk);
    chk("cfg_err_clr", 32'(bus.cfg_err), 0);
    chk("cfg_err_valid2", 32'(bus.idx_valid), 0);
  endtask

  initial begin
    int vc;
    int rn;
    int rt;
    int ab;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.step_ready = 1'b0;
    bus.cfg_inner_n = '0;
    bus.cfg_outer_n = '0;
    #1 rst = 1'b1;
    #2;
    chk_idle("reset");
    chk("reset_done", 32'(bus.done), 0);
    chk("reset_cfg_err", 32'(bus.cfg_err), 0);
    chk("reset_last", 32'(bus.inner_last), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_seq(3, 2, 0, -1, 1'b0, vc);
    chk("cycles_3x2", 32'(vc), 6);
    run_seq(4, 1, 1, -1, 1'b0, vc);
    chk("cycles_toggle", 32'(vc), 8);

    bad_cfg(0, 5);
    bad_cfg(5, 0);

    // abort wins over start: neither a config error nor a launch
    bus.cfg_inner_n = '0;
    bus.cfg_outer_n = '0;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    chk("abort_start_cfg_err", 32'(bus.cfg_err), 0);
    bus.cfg_inner_n = IW'(2);
    bus.cfg_outer_n = OW'(2);
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk_idle("abort_start");

    run_seq(31, 31, 0, -1, 1'b0, vc);
    chk("cycles_31x31", 32'(vc), 961);

    run_seq(3, 3, 0, 4, 1'b0, vc);
    run_seq(2, 1, 0, -1, 1'b0, vc);
    chk("cycles_after_abort", 32'(vc), 2);

    // async reset mid-run, observed between clock edges
    bus.cfg_inner_n = IW'(5);
    bus.cfg_outer_n = OW'(4);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.step_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_j", 32'(bus.inner_j), 4);
    #2 rst = 1'b1;
    #1;
    chk_idle("async_rst");
    chk("async_rst_done", 32'(bus.done), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.step_ready = 1'b0;
    @(negedge clk);
    chk_idle("post_rst");
    chk("post_rst_done", 32'(bus.done), 0);

    repeat (14) begin
      rn = $urandom_range(1, 6);
      rt = $urandom_range(1, 5);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, rn * rt - 1)) : -1;
      run_seq(rn, rt, 2, ab, 1'b1, vc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
